// File: rtl/seg7_pkg.sv
// Shared constants and the active-low hex-to-segment decode for the seg7 display slice.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g} patterns for nibble values 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display-driver bus: content/load from the datapath, pin-level segment/anode outputs back.
interface seg7_scan_if #(
  parameter int unsigned NDIG = 8
);
  logic [4*NDIG-1:0] val;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   blank_mask;
  logic              load;
  logic [6:0]        seg;
  logic              dp_n;
  logic [NDIG-1:0]   an;

  modport master (output val, dp, blank_mask, load, input seg, dp_n, an);
  modport slave  (input val, dp, blank_mask, load, output seg, dp_n, an);
endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational 4-to-7 active-low segment decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = hex2seg(hex);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment scanner with shadow registers and one dark cycle per slot.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [4*NDIG-1:0] sh_val;
  logic [NDIG-1:0]   sh_dp;
  logic [NDIG-1:0]   sh_blank;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic [NDIG-1:0]   lz_blank;
  logic [3:0]        nib;
  logic [6:0]        dec_seg;
  logic [NDIG-1:0]   an_d;
  logic [6:0]        seg_d;
  logic              dp_n_d;

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign nib  = sh_val[{idx, 2'b00} +: 4];

  seg7_hex_dec u_dec (
    .hex   (nib),
    .seg_c (dec_seg)
  );

  // Prefix-OR from the MSB: a digit is a leading zero when it and everything above it is zero.
`ifdef SEG7_LZB_EN
  always_comb begin : lzb_mask
    logic acc;
    acc      = 1'b0;
    lz_blank = '0;
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      acc         = acc | (|sh_val[4*i +: 4]);
      lz_blank[i] = ~acc;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Next output image: dark on the slot-boundary cycle or for blanked digits.
  always_comb begin
    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (!tick && !sh_blank[idx] && !lz_blank[idx]) begin
      an_d   = ~(NDIG'(1) << idx);
      seg_d  = dec_seg;
      dp_n_d = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      cnt      <= '0;
      idx      <= '0;
      bus.an   <= '1;
      bus.seg  <= SEG_OFF;
      bus.dp_n <= 1'b1;
    end else begin
      if (bus.load) begin
        sh_val   <= bus.val;
        sh_dp    <= bus.dp;
        sh_blank <= bus.blank_mask;
      end
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end
      bus.an   <= an_d;
      bus.seg  <= seg_d;
      bus.dp_n <= dp_n_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with NDIG=4, SCAN_DIV=4: vector table plus multi-cycle sequences.
module tb_seg7_scan;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned SCAN_DIV = 4;

  typedef struct {
    logic        load;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec;
  int   nfail;
  int   ncyc;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  vec_t vt[20];

  logic [6:0] hex_tb [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clk = ~clk;

  seg7_scan_if #(.NDIG(NDIG)) bus ();

  seg7_scan #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mkv(input logic ld, input logic [3:0] an, input logic [6:0] sg, input logic dpn);
    vec_t v;
    v.load = ld; v.val = 16'h1A2F; v.dp = 4'b0100; v.blank = 4'b0000;
    v.an = an; v.seg = sg; v.dpn = dpn;
    return v;
  endfunction

  // Expected outputs after the n-th edge since reset, given the shadow contents before that edge.
  function automatic void model(input int n, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                                output logic [3:0] ean, output logic [6:0] eseg, output logic edpn);
    int   k;
    logic lz;
    k    = ((n - 1) / 4) % 4;
    lz   = 1'b0;
    ean  = 4'hF;
    eseg = 7'b1111111;
    edpn = 1'b1;
`ifdef SEG7_LZB_EN
    if (k > 0 && (v >> (4 * k)) == 16'h0) lz = 1'b1;
`endif
    if ((n % 4) != 0 && !b[k] && !lz) begin
      ean  = ~(4'b0001 << k);
      eseg = hex_tb[v[4*k +: 4]];
      edpn = ~d[k];
    end
  endfunction

  task automatic check_vec(input string nm, input logic [3:0] ean, input logic [6:0] es, input logic ed);
    nvec++;
    if (bus.an !== ean || bus.seg !== es || bus.dp_n !== ed) begin
      nfail++;
      $display("FAIL %s cyc=%0d: an=%b seg=%b dp_n=%b, expected an=%b seg=%b dp_n=%b",
               nm, ncyc, bus.an, bus.seg, bus.dp_n, ean, es, ed);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", nm, ncyc, act, exp);
    end
  endtask

  // One clock edge with the given inputs; returns the model's expectation for this edge.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                       output logic [3:0] ean, output logic [6:0] eseg, output logic edpn);
    bus.load = ld; bus.val = v; bus.dp = d; bus.blank_mask = b;
    model(ncyc + 1, m_val, m_dp, m_blank, ean, eseg, edpn);
    @(posedge clk);
    #1;
    ncyc++;
    if (ld) begin
      m_val = v; m_dp = d; m_blank = b;
    end
    bus.load = 1'b0;
  endtask

  task automatic run_model(input string nm, input int n);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, m_val, m_dp, m_blank, ea, es, ed);
      check_vec(nm, ea, es, ed);
    end
  endtask

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    int         zeros;

    nvec = 0; nfail = 0; ncyc = 0;
    m_val = '0; m_dp = '0; m_blank = '0;
    rst = 1'b1;
    bus.load = 1'b0; bus.val = '0; bus.dp = '0; bus.blank_mask = '0;

    @(posedge clk); #1;
    check_vec("reset_state", 4'hF, 7'b1111111, 1'b1);
    rst = 1'b0;

    // Scan order after loading 1A2F; the load edge itself still shows the empty shadow.
    vt[0]  = mkv(1'b1, 4'b1110, 7'b0000001, 1'b1);
    vt[1]  = mkv(1'b0, 4'b1110, 7'b0111000, 1'b1);
    vt[2]  = mkv(1'b0, 4'b1110, 7'b0111000, 1'b1);
    vt[3]  = mkv(1'b0, 4'b1111, 7'b1111111, 1'b1);
    vt[4]  = mkv(1'b0, 4'b1101, 7'b0010010, 1'b1);
    vt[5]  = mkv(1'b0, 4'b1101, 7'b0010010, 1'b1);
    vt[6]  = mkv(1'b0, 4'b1101, 7'b0010010, 1'b1);
    vt[7]  = mkv(1'b0, 4'b1111, 7'b1111111, 1'b1);
    vt[8]  = mkv(1'b0, 4'b1011, 7'b0001000, 1'b0);
    vt[9]  = mkv(1'b0, 4'b1011, 7'b0001000, 1'b0);
    vt[10] = mkv(1'b0, 4'b1011, 7'b0001000, 1'b0);
    vt[11] = mkv(1'b0, 4'b1111, 7'b1111111, 1'b1);
    vt[12] = mkv(1'b0, 4'b0111, 7'b1001111, 1'b1);
    vt[13] = mkv(1'b0, 4'b0111, 7'b1001111, 1'b1);
    vt[14] = mkv(1'b0, 4'b0111, 7'b1001111, 1'b1);
    vt[15] = mkv(1'b0, 4'b1111, 7'b1111111, 1'b1);
    vt[16] = mkv(1'b0, 4'b1110, 7'b0111000, 1'b1);
    vt[17] = mkv(1'b0, 4'b1110, 7'b0111000, 1'b1);
    vt[18] = mkv(1'b0, 4'b1110, 7'b0111000, 1'b1);
    vt[19] = mkv(1'b0, 4'b1111, 7'b1111111, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].load, vt[i].val, vt[i].dp, vt[i].blank, ea, es, ed);
      check_vec($sformatf("scan_vec%0d", i), vt[i].an, vt[i].seg, vt[i].dpn);
    end

    // Exclusivity and dead-time cadence over 64 cycles.
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, m_val, m_dp, m_blank, ea, es, ed);
      zeros = 0;
      for (int j = 0; j < 4; j++) if (bus.an[j] == 1'b0) zeros++;
      check_int("an_onehot", int'(zeros <= 1), 1);
      check_int("dead_time", int'(bus.an == 4'hF), int'((ncyc % 4) == 0));
    end

    // Load on the tick cycle: next slot must already show the new nibble.
    for (int i = 0; i < 8 && ((ncyc + 1) % 4) != 0; i++) cycle(1'b0, m_val, m_dp, m_blank, ea, es, ed);
    check_int("tick_align", (ncyc + 1) % 4, 0);
    cycle(1'b1, 16'h3456, 4'b0001, 4'b0000, ea, es, ed);
    check_vec("tick_load_dark", 4'hF, 7'b1111111, 1'b1);
    run_model("tick_load_next", 16);

    // Blank digit 1: never enabled, other slots keep their timing.
    cycle(1'b1, 16'h3456, 4'b0000, 4'b0010, ea, es, ed);
    check_vec("blank_load", ea, es, ed);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, m_val, m_dp, m_blank, ea, es, ed);
      check_vec("blank_scan", ea, es, ed);
      check_int("blank_never_1101", int'(bus.an == 4'b1101), 0);
    end

    // Leading zeros: 0050 then 0000.
    cycle(1'b1, 16'h0050, 4'b0000, 4'b0000, ea, es, ed);
    check_vec("lz_load", ea, es, ed);
    run_model("lz_0050", 16);
    cycle(1'b1, 16'h0000, 4'b0000, 4'b0000, ea, es, ed);
    check_vec("lz_zero_load", ea, es, ed);
    run_model("lz_0000", 16);

    // Reset in the middle of a lit slot takes effect without a clock edge.
    cycle(1'b1, 16'h1A2F, 4'b0100, 4'b0000, ea, es, ed);
    for (int i = 0; i < 8 && (ncyc % 4) != 1; i++) cycle(1'b0, m_val, m_dp, m_blank, ea, es, ed);
    check_int("lit_before_reset", int'(bus.an != 4'hF), 1);
    #1 rst = 1'b1;
    #1;
    check_vec("reset_midframe", 4'hF, 7'b1111111, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    ncyc = 0; m_val = '0; m_dp = '0; m_blank = '0;
    cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, ea, es, ed);
    check_vec("post_reset_digit0", 4'b1110, 7'b0000001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
